// File: rtl/chip8_alu.sv
// -----------------------------------------------------------------------------
// chip8_alu
// Registered 16-bit ALU for the Chip-8 CPU execute stage. One operation can be
// issued every clock; the result and the carry/borrow flag (destined for VF)
// appear after the rising edge that samples the operands.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   input1     in  16   operand A (unsigned)
//   input2     in  16   operand B (unsigned); shifts use input2[3:0] only
//   sel        in   4   operation select (ALU_f encoding, see alu_f_t)
//   out        out 16   registered result
//   alu_carry  out  1   registered carry/borrow flag
//
// Optional build macro: CHIP8_ALU_SHIFT_CARRY_EN
//   When defined, LSHIFT/RSHIFT report the last bit shifted out on alu_carry
//   (0 for a shift amount of 0). Results are identical in both builds.
//
// Interface timing: there is no handshake. Every rising edge with reset low
// captures a new result; outputs hold until the next edge.
// -----------------------------------------------------------------------------
module chip8_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] input1,
  input  logic [15:0] input2,
  input  logic [3:0]  sel,
  output logic [15:0] out,
  output logic        alu_carry
);

  typedef enum logic [3:0] {
    ALU_NOP     = 4'd0,
    ALU_OR      = 4'd1,
    ALU_AND     = 4'd2,
    ALU_XOR     = 4'd3,
    ALU_ADD     = 4'd4,
    ALU_MINUS   = 4'd5,
    ALU_LSHIFT  = 4'd6,
    ALU_RSHIFT  = 4'd7,
    ALU_EQUALS  = 4'd8,
    ALU_GREATER = 4'd9,
    ALU_INC     = 4'd10
  } alu_f_t;

  logic [15:0] r_out;
  logic        r_carry;

  logic [15:0] w_result;
  logic        w_carry;
  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [3:0]  w_amt;

  assign w_amt  = input2[3:0];
  // 17-bit arithmetic: bit 16 of the difference is the borrow.
  assign w_sum  = {1'b0, input1} + {1'b0, input2};
  assign w_diff = {1'b0, input1} - {1'b0, input2};

`ifdef CHIP8_ALU_SHIFT_CARRY_EN
  // One guard bit on each side catches the last bit shifted out:
  // w_lsh[16] = input1[16-amt], w_rsh[0] = input1[amt-1]; both are 0 for amt=0.
  logic [16:0] w_lsh;
  logic [16:0] w_rsh;
  assign w_lsh = {1'b0, input1} << w_amt;
  assign w_rsh = {input1, 1'b0} >> w_amt;
`else
  logic [15:0] w_lsh;
  logic [15:0] w_rsh;
  assign w_lsh = input1 << w_amt;
  assign w_rsh = input1 >> w_amt;
`endif

  always_comb begin
    w_result = 16'h0000;
    w_carry  = 1'b0;
    case (alu_f_t'(sel))
      ALU_NOP: begin
        w_result = 16'h0000;
      end
      ALU_OR:  w_result = input1 | input2;
      ALU_AND: w_result = input1 & input2;
      ALU_XOR: w_result = input1 ^ input2;
      ALU_ADD: begin
        w_result = w_sum[15:0];
        // Chip-8 registers are 8 bits wide, so overflow means a sum above 255.
        w_carry  = (w_sum > 17'd255);
      end
      ALU_MINUS: begin
        w_result = w_diff[15:0];
        w_carry  = w_diff[16];
      end
`ifdef CHIP8_ALU_SHIFT_CARRY_EN
      ALU_LSHIFT: begin
        w_result = w_lsh[15:0];
        w_carry  = w_lsh[16];
      end
      ALU_RSHIFT: begin
        w_result = w_rsh[16:1];
        w_carry  = w_rsh[0];
      end
`else
      ALU_LSHIFT: w_result = w_lsh;
      ALU_RSHIFT: w_result = w_rsh;
`endif
      ALU_EQUALS:  w_result = {15'd0, (input1 == input2)};
      ALU_GREATER: w_result = {15'd0, (input1 > input2)};
      ALU_INC:     w_result = input1 + 16'd1;
      default: begin
        w_result = 16'h0000;
        w_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= 16'h0000;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_result;
      r_carry <= w_carry;
    end
  end

  assign out       = r_out;
  assign alu_carry = r_carry;

endmodule

// File: tb/tb_chip8_alu.sv
// -----------------------------------------------------------------------------
// tb_chip8_alu
// Self-checking bench for chip8_alu. The driver issues operations on the
// falling edge and pushes the reference-model answer {carry, out} into exp_q;
// the monitor pops and compares one entry after every rising edge on which an
// operation was issued.
// -----------------------------------------------------------------------------
module tb_chip8_alu;

  logic        clk;
  logic        reset;
  logic [15:0] input1;
  logic [15:0] input2;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        alu_carry;

  logic        tb_valid;
  logic [16:0] exp_q[$];
  int          op_q[$];
  int          n_checks;
  int          n_fail;

  chip8_alu dut (
    .clk       (clk),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .sel       (sel),
    .out       (out),
    .alu_carry (alu_carry)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  // Computed from the arithmetic rules with plain integers.
  function automatic logic [16:0] model(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned n  = b & 16'h000F;
    int unsigned r  = 0;
    bit          c  = 1'b0;
    case (op)
      4'd1:  r = ua | ub;
      4'd2:  r = ua & ub;
      4'd3:  r = ua ^ ub;
      4'd4:  begin r = (ua + ub) % 65536; c = (ua + ub) > 255; end
      4'd5:  begin r = (ua + 65536 - ub) % 65536; c = (ua < ub); end
      4'd6:  begin
        r = (ua * (1 << n)) % 65536;
`ifdef CHIP8_ALU_SHIFT_CARRY_EN
        c = (n != 0) && (((ua * (1 << n)) / 65536) % 2 == 1);
`endif
      end
      4'd7:  begin
        r = ua / (1 << n);
`ifdef CHIP8_ALU_SHIFT_CARRY_EN
        c = (n != 0) && ((ua / (1 << (n - 1))) % 2 == 1);
`endif
      end
      4'd8:  r = (ua == ub) ? 1 : 0;
      4'd9:  r = (ua > ub) ? 1 : 0;
      4'd10: r = (ua + 1) % 65536;
      default: r = 0;
    endcase
    return {c, r[15:0]};
  endfunction

  // --------------------------------------------------------------- driver
  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    sel      = op;
    input1   = a;
    input2   = b;
    tb_valid = 1'b1;
    exp_q.push_back(model(op, a, b));
    op_q.push_back(int'(op));
  endtask

  task automatic idle();
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  task automatic check_direct(input string name, input logic [16:0] act,
                              input logic [16:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got carry=%0b out=%h, required carry=%0b out=%h",
               name, act[16], act[15:0], req[16], req[15:0]);
    end
  endtask

  // -------------------------------------------------------------- monitor
  initial begin
    logic        v;
    logic        rs;
    logic [16:0] e;
    int          op;
    forever begin
      @(posedge clk);
      v  = tb_valid;
      rs = reset;
      #1;
      if (v && !rs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: got out=%h with no expected entry", out);
        end else begin
          e  = exp_q.pop_front();
          op = op_q.pop_front();
          if ({alu_carry, out} !== e) begin
            n_fail++;
            $display("FAIL op%0d: got carry=%0b out=%h, required carry=%0b out=%h",
                     op, alu_carry, out, e[16], e[15:0]);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int unsigned acc;
    n_checks = 0;
    n_fail   = 0;
    tb_valid = 1'b0;
    reset    = 1'b0;
    sel      = 4'd0;
    input1   = 16'h0;
    input2   = 16'h0;

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1 check_direct("reset_async", {alu_carry, out}, 17'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Logic ops.
    issue(4'd1, 16'hF5A0, 16'hFA50);
    issue(4'd2, 16'hF5A0, 16'hFA50);
    issue(4'd3, 16'hF5A0, 16'hFA50);
    // ADD / MINUS.
    issue(4'd4, 16'd180, 16'd180);
    issue(4'd4, 16'd5, 16'd5);
    issue(4'd4, 16'hFFFF, 16'd1);
    issue(4'd5, 16'hC3C3, 16'hC3C3);
    issue(4'd5, 16'hE0A5, 16'h7003);
    issue(4'd5, 16'h7003, 16'hE0A5);
    // Shifts, including amount 0 and amount 15.
    issue(4'd6, 16'h0031, 16'd2);
    issue(4'd6, 16'h1111, 16'd1);
    issue(4'd7, 16'h0031, 16'd2);
    issue(4'd7, 16'h1111, 16'd1);
    issue(4'd7, 16'h0031, 16'd1);
    issue(4'd6, 16'hABCD, 16'h0010);
    issue(4'd7, 16'h8001, 16'h000F);
    issue(4'd6, 16'h8001, 16'h000F);
    // Compares.
    issue(4'd8, 16'd8, 16'd8);
    issue(4'd8, 16'd8, 16'd9);
    issue(4'd9, 16'd180, 16'd15);
    issue(4'd9, 16'd15, 16'd180);
    issue(4'd9, 16'd15, 16'd15);
    // INC edge, undefined select, NOP.
    issue(4'd10, 16'hFFFF, 16'h1234);
    issue(4'd15, 16'hFFFF, 16'hFFFF);
    issue(4'd0, 16'hFFFF, 16'hFFFF);

    // INC with the registered result fed back as operand A.
    issue(4'd10, 16'd8, 16'd0);
    acc = 9;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      sel      = 4'd10;
      input1   = out;
      input2   = 16'($urandom);
      tb_valid = 1'b1;
      exp_q.push_back(model(4'd10, 16'(acc), 16'd0));
      op_q.push_back(10);
      acc++;
    end
    idle();
    check_direct("inc_feedback_final", {alu_carry, out}, {1'b0, 16'd24});

    // Reset asserted with an operation pending discards it.
    issue(4'd1, 16'hF5A0, 16'hFA50);
    @(negedge clk);
    tb_valid = 1'b0;
    sel      = 4'd4;
    input1   = 16'd180;
    input2   = 16'd180;
    #2 reset = 1'b1;
    #1 check_direct("reset_midop", {alu_carry, out}, 17'h0);
    @(posedge clk);
    #1 check_direct("reset_held", {alu_carry, out}, 17'h0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized operations across all select codes.
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      issue(op, a, b);
    end
    idle();
    @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
